reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the next-generation RISC-V core; replaces the fixed 2R/1W 32x32 array.
- Configurable width, depth, read-port count and write-port count.
- Registered (1-cycle) reads with optional write-to-read bypass and hardwired-zero register 0.
- Clears the array with a sequential init sweep instead of a wide asynchronous reset, and exposes `ready` to the pipeline.

---
 rtl/rf_pkg.sv | 34 +++
 rtl/rf_read_port.sv | 33 +++
 rtl/reg_file_mp.sv | 115 +++++++++++
 tb/tb_reg_file_mp.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Used by reg_file_mp and rf_read_port.
package rf_pkg;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Upper bounds for the generic winner search below; port vectors are zero-extended into these.
  localparam int MAX_AW = 16;
  localparam int MAX_WR = 16;
  localparam int WA_W   = MAX_WR * MAX_AW;

  // Returns the highest-index enabled write port targeting addr, or -1 when none does.
  function automatic int win_port(input logic [MAX_AW-1:0] addr,
                                  input logic [MAX_WR-1:0] en,
                                  input logic [WA_W-1:0]   addrs,
                                  input int                aw,
                                  input int                nwr);
    int w;
    logic [MAX_AW-1:0] mask;
    w    = -1;
    mask = MAX_AW'((1 << aw) - 1);
    for (int j = 0; j < nwr; j++) begin
      if (en[j] && ((MAX_AW'(addrs >> (j * aw)) & mask) == addr)) w = j;
    end
    return w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: address-0 forcing, optional bypass select, and
// output gating so nothing but zero leaves the port while the array is not ready.
module rf_read_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            active,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            byp_hit,
  input  logic [XLEN-1:0] byp_data,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] sampled;
  logic [XLEN-1:0] rd_q;

  always_comb begin
    sampled = '0;
    if (addr != '0) sampled = byp_hit ? byp_data : mem_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_q <= '0;
    else        rd_q <= active ? sampled : '0;
  end

  // A read captured on the edge that starts a clear sweep must not leak out during INIT.
  assign rd_data = active ? rd_q : '0;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with sequential init sweep and hardwired x0.
// Define RF_BYPASS_EN to forward same-edge write data to matching read ports.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  parameter int  NRD   = 2,
  parameter int  NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data
);

  rf_state_e       state, state_n;
  logic [AW-1:0]   init_cnt, init_cnt_n;
  logic [XLEN-1:0] mem [NREGS];
  logic [NWR-1:0]  we_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RF_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    case (state)
      RF_INIT: begin
        init_cnt_n = init_cnt + 1'b1;
        if (init_cnt == AW'(NREGS - 1)) state_n = RF_READY;
      end
      RF_READY: begin
        if (clear_req) begin
          state_n    = RF_INIT;
          init_cnt_n = '0;
        end
      end
      default: state_n = RF_INIT;
    endcase
  end

  assign ready = (state == RF_READY);

  // A clear request on the same edge kills every write, and x0 is never stored.
  always_comb begin
    we_eff = '0;
    for (int j = 0; j < NWR; j++) begin
      we_eff[j] = ready && !clear_req && wr_en[j] && (wr_addr[j*AW +: AW] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (state == RF_INIT) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we_eff[j]) mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    assign addr = rd_addr[i*AW +: AW];

`ifdef RF_BYPASS_EN
    int win;

    always_comb begin
      win      = win_port(MAX_AW'(addr), MAX_WR'(we_eff), WA_W'(wr_addr), AW, NWR);
      byp_hit  = 1'b0;
      byp_data = '0;
      if (win >= 0) begin
        byp_hit  = 1'b1;
        byp_data = wr_data[win*XLEN +: XLEN];
      end
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_data = '0;
`endif

    rf_read_port #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .active  (ready),
      .addr    (addr),
      .mem_data(mem[addr]),
      .byp_hit (byp_hit),
      .byp_data(byp_data),
      .rd_data (rd_data[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic
// compared against an array-based reference model (honours RF_BYPASS_EN).
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                clear_req = 1'b0;
  logic                ready;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;

  int checks = 0;
  int failures = 0;

  logic [XLEN-1:0] model [NREGS];
  int init_left = NREGS;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .ready    (ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NRD*AW-1:0] pa(input int a1, input int a0);
    return {AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NWR*XLEN-1:0] pd(input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d0);
    return {d1, d0};
  endfunction

  // Drives one cycle of inputs at a falling edge, predicts the next rising edge, checks after it.
  task automatic applyStimulus(input logic clr, input logic [NWR-1:0] we, input logic [NWR*AW-1:0] wa,
                               input logic [NWR*XLEN-1:0] wd, input logic [NRD*AW-1:0] ra);
    logic [XLEN-1:0] exp_rd [NRD];
    bit was_ready;
    bit ready_exp;
    clear_req = clr;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr   = ra;
    was_ready = (init_left == 0);
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = ra[i*AW +: AW];
      exp_rd[i] = '0;
      if (was_ready && !clr && a != 0) begin
        exp_rd[i] = model[a];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NWR; j++)
          if (we[j] && wa[j*AW +: AW] == a) exp_rd[i] = wd[j*XLEN +: XLEN];
`endif
      end
    end
    if (!was_ready) begin
      model[NREGS - init_left] = '0;
      init_left--;
    end else if (clr) begin
      init_left = NREGS;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && wa[j*AW +: AW] != 0) model[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
    end
    ready_exp = (init_left == 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready", {31'b0, ready}, {31'b0, ready_exp});
    for (int i = 0; i < NRD; i++)
      checkOutput($sformatf("rd_data%0d", i), rd_data[i*XLEN +: XLEN], ready_exp ? exp_rd[i] : '0);
  endtask

  task automatic randomStep(input int clr_pct);
    applyStimulus($urandom_range(0, 99) < clr_pct, NWR'($urandom), pa($urandom_range(0, 31), $urandom_range(0, 31)),
                  pd($urandom, $urandom), pa($urandom_range(0, 31), $urandom_range(0, 31)));
  endtask

  task automatic readAll();
    for (int k = 0; k < NREGS / 2; k++) applyStimulus(1'b0, '0, '0, '0, pa(2*k + 1, 2*k));
  endtask

  // Asserts reset at a falling edge, checks the asynchronous effect, releases after a few cycles.
  task automatic doReset(input int cycles);
    reset = 1'b0;
    wr_en = NWR'(3);
    #1;
    checkOutput("reset_ready", {31'b0, ready}, '0);
    checkOutput("reset_rd0", rd_data[0 +: XLEN], '0);
    checkOutput("reset_rd1", rd_data[XLEN +: XLEN], '0);
    repeat (cycles) @(negedge clk);
    checkOutput("reset_hold_ready", {31'b0, ready}, '0);
    reset = 1'b1;
    init_left = NREGS;
  endtask

  initial begin
    @(negedge clk);
    doReset(3);

    $display("[TB] initial sweep with ignored writes and clears");
    for (int c = 0; c < NREGS; c++) randomStep(20);
    readAll();

    $display("[TB] basic write then read");
    applyStimulus(1'b0, 2'b01, pa(0, 5), pd('0, 32'hDEADBEEF), pa(0, 0));
    applyStimulus(1'b0, 2'b00, '0, '0, pa(5, 0));

    $display("[TB] write port priority and x0");
    applyStimulus(1'b0, 2'b11, pa(7, 7), pd(32'h22222222, 32'h11111111), pa(0, 0));
    applyStimulus(1'b0, 2'b11, pa(0, 0), pd(32'hFFFFFFFF, 32'hFFFFFFFF), pa(7, 7));
    applyStimulus(1'b0, 2'b00, '0, '0, pa(0, 0));

    $display("[TB] same-cycle write and read");
    applyStimulus(1'b0, 2'b01, pa(0, 9), pd('0, 32'hA5A5A5A5), pa(9, 9));
    applyStimulus(1'b0, 2'b00, '0, '0, pa(9, 9));
    applyStimulus(1'b0, 2'b11, pa(12, 12), pd(32'h0BADF00D, 32'h00C0FFEE), pa(12, 0));
    applyStimulus(1'b0, 2'b00, '0, '0, pa(0, 12));

    $display("[TB] fill then clear with colliding write");
    for (int k = 1; k < NREGS; k++)
      applyStimulus(1'b0, 2'b01, pa(0, k), pd('0, 32'h01010101 * k + 32'h10), pa(k, k - 1));
    applyStimulus(1'b1, 2'b01, pa(0, 3), pd('0, 32'h1234), pa(3, 4));
    for (int c = 0; c < NREGS; c++) randomStep(30);
    readAll();

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) randomStep(2);
    while (init_left != 0) randomStep(0);
    readAll();

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(1'b1, '0, '0, '0, '0);
    for (int c = 0; c < 9; c++) randomStep(0);
    doReset(2);
    for (int c = 0; c < NREGS; c++) randomStep(10);
    readAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
